// File: rtl/pixel_replication_2x_stream_pkg.sv
// ----------------------------------------------------------------------------
// img_scale_pkg
// Shared definitions for the 2x image scaling blocks (reducer and replicator).
//   state_t          : row-phase encoding for the replicator FSM
//   *_DEF localparams: default frame geometry and pixel width
// ----------------------------------------------------------------------------
package img_scale_pkg;

  localparam int LARGURA_IN_DEF = 4;
  localparam int ALTURA_IN_DEF  = 4;
  localparam int PIXEL_W_DEF    = 8;

  // ST_ROW_A: first output copy of an input row, pixels arrive from the stream.
  // ST_ROW_B: second output copy, replayed from the line buffer.
  typedef enum logic {
    ST_ROW_A = 1'b0,
    ST_ROW_B = 1'b1
  } state_t;

endpackage

// File: rtl/pixel_replication_2x_stream_line_buffer_ram.sv
// ----------------------------------------------------------------------------
// line_buffer_ram
// One-row pixel store: DEPTH x DATA_W, one synchronous write port and one
// asynchronous read port sharing a single address.
// Ports:
//   clock : write clock
//   we    : write enable
//   addr  : column address for both write and read
//   wdata : pixel to store
//   rdata : pixel currently stored at addr (combinational)
// Contents are not reset.
// ----------------------------------------------------------------------------
module line_buffer_ram #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/pixel_replication_2x_stream.sv
// ----------------------------------------------------------------------------
// pixel_replication_2x_stream
// Streaming 2x nearest-neighbour upscaler: out(r,c) = in(r/2, c/2).
// Input row pixels are emitted twice as they arrive (ST_ROW_A) while being
// stored in a line buffer; the row is then replayed from the buffer
// (ST_ROW_B) to form the second output row.
// Ports:
//   clock, reset      : single clock, synchronous active-high reset
//   s_valid/s_ready   : input handshake, s_pixel in raster order
//   m_valid/m_ready   : output handshake, m_pixel from a single output register
//   m_sol             : first beat of an output row
//   m_last            : final beat of an output frame
//   frame_count       : completed output frames (only with UPSCALE_FRAME_CNT_EN)
// Optional feature macro: UPSCALE_FRAME_CNT_EN
// ----------------------------------------------------------------------------
module pixel_replication_2x_stream
  import img_scale_pkg::*;
#(
  parameter int LARGURA_IN = LARGURA_IN_DEF,
  parameter int ALTURA_IN  = ALTURA_IN_DEF,
  parameter int PIXEL_W    = PIXEL_W_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [PIXEL_W-1:0] s_pixel,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [PIXEL_W-1:0] m_pixel,
  output logic               m_sol,
  output logic               m_last
`ifdef UPSCALE_FRAME_CNT_EN
  ,
  output logic [15:0]        frame_count
`endif
);

  localparam int COL_W = $clog2(LARGURA_IN);
  // A single-row frame still needs a 1-bit row register.
  localparam int ROW_W = (ALTURA_IN > 1) ? $clog2(ALTURA_IN) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(LARGURA_IN - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ALTURA_IN - 1);

  state_t             state;
  state_t             state_nxt;
  logic [COL_W-1:0]   col;
  logic [ROW_W-1:0]   row;
  // In ST_ROW_A: the accepted pixel still owes its repeat beat.
  // In ST_ROW_B: the first copy of linebuf[col] has been emitted.
  logic               dup;

  logic               slot_free;
  logic               accept;
  logic               a_dup_beat;
  logic               b_beat;
  logic               col_end;
  logic               row_end;
  logic [PIXEL_W-1:0] lb_rdata;

  line_buffer_ram #(
    .DEPTH  (LARGURA_IN),
    .ADDR_W (COL_W),
    .DATA_W (PIXEL_W)
  ) u_line_buffer (
    .clock (clock),
    .we    (accept),
    .addr  (col),
    .wdata (s_pixel),
    .rdata (lb_rdata)
  );

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_ROW_A;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_ROW_A: if (a_dup_beat && col_end)   state_nxt = ST_ROW_B;
      ST_ROW_B: if (b_beat && dup && col_end) state_nxt = ST_ROW_A;
      default:  state_nxt = ST_ROW_A;
    endcase
  end

  // Output / beat-qualifier logic
  always_comb begin
    slot_free  = !m_valid || m_ready;
    col_end    = (col == COL_LAST);
    row_end    = (row == ROW_LAST);
    s_ready    = (state == ST_ROW_A) && !dup && slot_free;
    accept     = s_ready && s_valid;
    a_dup_beat = (state == ST_ROW_A) && dup && slot_free;
    b_beat     = (state == ST_ROW_B) && slot_free;
  end

  // Column / row / copy counters; wrap is by explicit compare.
  always_ff @(posedge clock) begin
    if (reset) begin
      col <= '0;
      row <= '0;
      dup <= 1'b0;
    end else if (accept) begin
      dup <= 1'b1;
    end else if (a_dup_beat) begin
      dup <= 1'b0;
      col <= col_end ? '0 : col + COL_W'(1);
    end else if (b_beat) begin
      dup <= !dup;
      if (dup) begin
        col <= col_end ? '0 : col + COL_W'(1);
        if (col_end) begin
          row <= row_end ? '0 : row + ROW_W'(1);
        end
      end
    end
  end

  // Output register stage: loads only when the slot is free, so a stalled
  // beat holds pixel and qualifiers stable.
  always_ff @(posedge clock) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_pixel <= '0;
      m_sol   <= 1'b0;
      m_last  <= 1'b0;
    end else if (slot_free) begin
      if (accept) begin
        m_valid <= 1'b1;
        m_pixel <= s_pixel;
        m_sol   <= (col == '0);
        m_last  <= 1'b0;
      end else if (a_dup_beat) begin
        // Repeat beat: m_pixel already holds the accepted pixel.
        m_valid <= 1'b1;
        m_sol   <= 1'b0;
        m_last  <= 1'b0;
      end else if (b_beat) begin
        m_valid <= 1'b1;
        m_pixel <= lb_rdata;
        m_sol   <= (col == '0) && !dup;
        m_last  <= dup && col_end && row_end;
      end else begin
        m_valid <= 1'b0;
        m_sol   <= 1'b0;
        m_last  <= 1'b0;
      end
    end
  end

`ifdef UPSCALE_FRAME_CNT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      frame_count <= 16'd0;
    end else if (m_valid && m_ready && m_last) begin
      frame_count <= frame_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pixel_replication_2x_stream.sv
module tb_pixel_replication_2x_stream;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int PW = 8;
  localparam int NB = 4 * W * H;

  logic          clock = 1'b0;
  logic          reset;
  logic          s_valid;
  logic          s_ready;
  logic [PW-1:0] s_pixel;
  logic          m_valid;
  logic          m_ready;
  logic [PW-1:0] m_pixel;
  logic          m_sol;
  logic          m_last;
`ifdef UPSCALE_FRAME_CNT_EN
  logic [15:0]   frame_count;
`endif

  pixel_replication_2x_stream #(
    .LARGURA_IN (W),
    .ALTURA_IN  (H),
    .PIXEL_W    (PW)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_pixel (s_pixel),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_pixel (m_pixel),
    .m_sol   (m_sol),
    .m_last  (m_last)
`ifdef UPSCALE_FRAME_CNT_EN
    ,
    .frame_count (frame_count)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [PW-1:0] px;
    logic          sol;
    logic          last;
  } beat_t;

  int            total = 0;
  int            bad   = 0;
  beat_t         expq[$];
  logic [PW-1:0] frame_px [W*H];
  int            n_in;
  int            beats_done;
  int            cyc = 0;
  int            ready_mode;
  int            valid_mode;
  bit            prev_stall = 1'b0;
  logic [PW-1:0] prev_px;
  logic          prev_sol;
  logic          prev_last;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: every output pixel is the input pixel at (r/2, c/2).
  task automatic build_model(input int base, input bit rnd);
    beat_t b;
    expq.delete();
    for (int i = 0; i < W*H; i++) frame_px[i] = rnd ? PW'($urandom) : PW'(base + i);
    for (int r = 0; r < 2*H; r++) begin
      for (int c = 0; c < 2*W; c++) begin
        b.px   = frame_px[(r/2)*W + c/2];
        b.sol  = (c == 0);
        b.last = (r == 2*H-1) && (c == 2*W-1);
        expq.push_back(b);
      end
    end
  endtask

  task automatic drive();
    bit v;
    case (valid_mode)
      0:       v = 1'b1;
      1:       v = (cyc % 3) != 2;
      default: v = 1'($urandom_range(0, 1));
    endcase
    if (n_in >= W*H) v = 1'b0;
    s_valid = v;
    s_pixel = (n_in < W*H) ? frame_px[n_in] : '0;
    m_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    cyc++;
  endtask

  task automatic sample();
    beat_t e;
    if (prev_stall) begin
      check("stall_valid", 32'(m_valid), 1);
      check("stall_px",    32'(m_pixel), 32'(prev_px));
      check("stall_sol",   32'(m_sol),   32'(prev_sol));
      check("stall_last",  32'(m_last),  32'(prev_last));
    end
    if (s_valid && s_ready) begin
      // Input pixel k of row r may only be taken once all earlier output
      // beats (2 per earlier column, 4W per earlier row) have been produced.
      check("accept_pos", 32'(beats_done + int'(m_valid)), 32'((n_in / W) * 4 * W + 2 * (n_in % W)));
      n_in++;
    end
    if (m_valid && m_ready) begin
      if (expq.size() == 0) begin
        check("extra_beat", 32'(beats_done), NB - 1);
      end else begin
        e = expq.pop_front();
        check("out_px",   32'(m_pixel), 32'(e.px));
        check("out_sol",  32'(m_sol),   32'(e.sol));
        check("out_last", 32'(m_last),  32'(e.last));
      end
      beats_done++;
    end
    prev_stall = (m_valid === 1'b1) && (m_ready === 1'b0);
    prev_px    = m_pixel;
    prev_sol   = m_sol;
    prev_last  = m_last;
  endtask

  task automatic run_frame(input int base, input bit rnd, input int rmode, input int vmode,
                           input int abort_at);
    int guard;
    build_model(base, rnd);
    n_in       = 0;
    beats_done = 0;
    ready_mode = rmode;
    valid_mode = vmode;
    guard      = 0;
    @(posedge clock); #1 drive();
    forever begin
      @(negedge clock);
      sample();
      guard++;
      if (beats_done >= NB) break;
      if (abort_at > 0 && beats_done >= abort_at) break;
      if (guard > 3000) begin
        check("frame_timeout", 32'(beats_done), NB);
        break;
      end
      @(posedge clock); #1 drive();
    end
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset   = 1'b1;
    s_valid = 1'b0;
    @(posedge clock); #1;
    reset      = 1'b0;
    prev_stall = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    s_valid = 1'b0;
    s_pixel = '0;
    m_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_m_valid", 32'(m_valid), 0);
    check("rst_m_pixel", 32'(m_pixel), 0);
    check("rst_m_sol",   32'(m_sol),   0);
    check("rst_m_last",  32'(m_last),  0);
    check("rst_s_ready", 32'(s_ready), 1);
`ifdef UPSCALE_FRAME_CNT_EN
    check("rst_frame_count", 32'(frame_count), 0);
`endif

    // Frame 0..15 at full rate: replication, m_sol and m_last positions.
    run_frame(0, 1'b0, 0, 0, 0);
    // Same frame with random downstream stalls.
    run_frame(0, 1'b0, 1, 0, 0);
    // Input gaps every third cycle.
    run_frame(0, 1'b0, 0, 1, 0);
    // Random pixels with random valid and ready.
    run_frame(0, 1'b1, 1, 2, 0);
    run_frame(0, 1'b1, 1, 1, 0);

    // Reset after 20 output beats abandons the frame.
    run_frame(40, 1'b0, 1, 0, 20);
    do_reset();
    @(negedge clock);
    check("midrst_m_valid", 32'(m_valid), 0);
    check("midrst_m_pixel", 32'(m_pixel), 0);
    run_frame(100, 1'b0, 0, 0, 0);

`ifdef UPSCALE_FRAME_CNT_EN
    do_reset();
    @(negedge clock);
    check("fc_after_reset", 32'(frame_count), 0);
    for (int k = 1; k <= 3; k++) begin
      run_frame(16 * k, 1'b1, 1, 2, 0);
      @(negedge clock);
      check("fc_frame", 32'(frame_count), 32'(k));
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
